// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer.
// Restoring divider on operand magnitudes, signs fixed up at the end.
module div_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_IT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nxt;

    logic [1:0]      r_op;
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_q;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_special;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_sub;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;

    // Two's-complement magnitude; the most negative value maps to itself.
    function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? ~(v - XLEN'(1)) : v;
    endfunction

    // Operand preparation and RISC-V special-case detection.
    always_comb begin
        w_signed  = ~r_op[0];
        w_abs_a   = w_signed ? f_abs(r_dvd) : r_dvd;
        w_abs_b   = w_signed ? f_abs(r_dvs) : r_dvs;
        w_div0    = (r_dvs == '0);
        w_ovf     = w_signed && (r_dvd == MIN_NEG) && (r_dvs == '1);
        w_special = w_div0 || w_ovf;
        if (w_div0) begin
            w_spec_res = r_op[1] ? r_dvd : '1;
        end else begin
            w_spec_res = r_op[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring step; the top bit of the shifted remainder
    // guarantees the subtraction fits once it is set.
    always_comb begin
        w_rem_sh  = {r_rem, r_a[XLEN-1]};
        w_ge      = w_rem_sh[XLEN] || (w_rem_sh[XLEN-1:0] >= r_b);
        w_rem_sub = w_rem_sh[XLEN-1:0] - r_b;
    end

    // Sign restoration of the raw quotient/remainder.
    always_comb begin
        w_q_fix = r_neg_q ? (~r_q + XLEN'(1)) : r_q;
        w_r_fix = r_neg_r ? (~r_rem + XLEN'(1)) : r_rem;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Next-state logic; flush returns to idle from anywhere.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_nxt = S_PREP;
                end
            end
            S_PREP: begin
                w_nxt = w_special ? S_FIX : S_DIV;
            end
            S_DIV: begin
                if (r_cnt == LAST_IT) begin
                    w_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_nxt = S_DONE;
            end
            S_DONE: begin
                if (result_ready) begin
                    w_nxt = S_IDLE;
                end
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
        if (flush) begin
            w_nxt = S_IDLE;
        end
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        start_ready  = (r_state == S_IDLE);
        busy         = (r_state != S_IDLE);
        result_valid = (r_state == S_DONE);
        result       = r_result;
    end

    // Datapath registers; a flushed op simply stops advancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_special <= 1'b0;
            r_result  <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_op  <= op;
                        r_dvd <= dividend;
                        r_dvs <= divisor;
                    end
                end
                S_PREP: begin
                    r_a       <= w_abs_a;
                    r_b       <= w_abs_b;
                    r_neg_q   <= w_signed &&
                                 (r_dvd[XLEN-1] ^ r_dvs[XLEN-1]);
                    r_neg_r   <= w_signed && r_dvd[XLEN-1];
                    r_rem     <= '0;
                    r_q       <= '0;
                    r_cnt     <= '0;
                    r_special <= w_special;
                    if (w_special) begin
                        r_result <= w_spec_res;
                    end
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
                    r_a   <= {r_a[XLEN-2:0], 1'b0};
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    if (!r_special) begin
                        r_result <= r_op[1] ? w_r_fix : w_q_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
